// File: rtl/sub_serial.sv
// sub_serial: digit-serial subtractor, O = A - B as an exact (N+1)-bit
// two's-complement result. W bits per cycle, LSB first, K = N/W cycles per op.
// A is added to the one's complement of B with the carry seeded to 1.
module sub_serial #(
  parameter int N      = 8,
  parameter int M      = N,
  parameter int W      = 1,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   O,
  output logic         busy
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_sh, bb_sh;     // operands, shifted right one digit per cycle
  logic [N-1:0]    s_q;             // partial sum, digits enter at the top
  logic [N-1:0]    bb_ext, s_nxt;
  logic            a_msb_q, bb_msb_q;
  logic            c_q;
  logic [CW-1:0]   cnt_q;
  logic [N:0]      o_q;
  logic [W-1:0]    dsum;
  logic [W:0]      cc;
  logic            last, accept, xa, xb;

  // B widened to the datapath width by sign or zero extension
  generate
    if (N > M) begin : g_ext
      assign bb_ext = {{(N-M){(SIGNED != 0) ? B[M-1] : 1'b0}}, B};
    end else begin : g_noext
      assign bb_ext = B;
    end
  endgenerate

  // One digit of ripple adder: A digit + ~BB digit + carry
  assign cc[0] = c_q;
  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic ab;
      assign ab        = a_sh[i] ^ ~bb_sh[i];
      assign dsum[i]   = ab ^ cc[i];
      assign cc[i+1]   = (a_sh[i] & ~bb_sh[i]) | (ab & cc[i]);
    end
  endgenerate

  // Assembled sum once the current digit is placed on top of the shifted history
  generate
    if (W == N) begin : g_one
      assign s_nxt = dsum;
    end else begin : g_many
      assign s_nxt = {dsum, s_q[N-1:W]};
    end
  endgenerate

  // Extension bits; unsigned operands extend with 0 so the MSB becomes ~carry (borrow)
  assign xa     = (SIGNED != 0) ? a_msb_q  : 1'b0;
  assign xb     = (SIGNED != 0) ? bb_msb_q : 1'b0;
  assign last   = (cnt_q == CW'(K-1));
  assign accept = (state_q == IDLE) && in_valid;
  assign O      = o_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one digit per RUN cycle, result on the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      bb_sh    <= '0;
      s_q      <= '0;
      a_msb_q  <= 1'b0;
      bb_msb_q <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      o_q      <= '0;
    end else if (accept) begin
      a_sh     <= A;
      bb_sh    <= bb_ext;
      s_q      <= '0;
      a_msb_q  <= A[N-1];
      bb_msb_q <= bb_ext[N-1];
      c_q      <= 1'b1;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> W;
      bb_sh <= bb_sh >> W;
      s_q   <= s_nxt;
      c_q   <= cc[W];
      cnt_q <= cnt_q + CW'(1);
      if (last) o_q <= {xa ^ ~xb ^ cc[W], s_nxt};
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: three configurations share clock and reset.
// u0: N=8 W=1 unsigned; u1: N=8 W=2 signed; u2: N=8 M=4 W=4 signed.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv [3];
  logic       ir [3];
  logic       ov [3];
  logic       ordy [3];
  logic       bsy [3];
  logic [7:0] a_in [3];
  logic [7:0] b_in [3];
  logic [8:0] o [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sub_serial #(.N(8), .W(1), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .A(a_in[0]), .B(b_in[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .O(o[0]), .busy(bsy[0]));
  sub_serial #(.N(8), .W(2), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .A(a_in[1]), .B(b_in[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .O(o[1]), .busy(bsy[1]));
  sub_serial #(.N(8), .M(4), .W(4), .SIGNED(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .A(a_in[2]), .B(b_in[2][3:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .O(o[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op on instance s, wait for out_valid, check latency/result, drain it.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp_o, input int exp_lat, input string tag);
    int n;
    chk({tag, " in_ready idle"}, 32'(ir[s]), 32'd1);
    a_in[s] = a; b_in[s] = b; iv[s] = 1'b1;
    @(posedge clk); #1;
    iv[s] = 1'b0; a_in[s] = 8'hA5; b_in[s] = 8'h5A;  // operands need not be held
    chk({tag, " busy run"}, 32'(bsy[s]), 32'd1);
    chk({tag, " in_ready run"}, 32'(ir[s]), 32'd0);
    n = 0;
    while (!ov[s] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " O"}, 32'(o[s]), 32'(exp_o));
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    chk({tag, " out_valid drop"}, 32'(ov[s]), 32'd0);
    chk({tag, " busy idle"}, 32'(bsy[s]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
    end
    #3;
    chk("reset O", 32'(o[0]), 32'd0);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset busy", 32'(bsy[0]), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(ir[0]), 32'd1);

    // Basic arithmetic across configurations
    run_op(0, 8'd5,   8'd3,   9'h002, 8, "u 5-3");
    run_op(0, 8'd3,   8'd5,   9'h1FE, 8, "u 3-5");
    run_op(0, 8'hFF,  8'h00,  9'h0FF, 8, "u 255-0");
    run_op(0, 8'h00,  8'hFF,  9'h101, 8, "u 0-255");
    run_op(1, 8'h80,  8'h7F,  9'h101, 4, "s -128-127");
    run_op(1, 8'h05,  8'hFD,  9'h008, 4, "s 5-(-3)");
    run_op(2, 8'h7F,  8'h0F,  9'h080, 2, "s4 127-(-1)");
    run_op(2, 8'h80,  8'h07,  9'h179, 2, "s4 -128-7");

    // Backpressure: hold DONE, in_valid pulses must be ignored
    a_in[0] = 8'd10; b_in[0] = 8'd4; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
    chk("bp out_valid", 32'(ov[0]), 32'd1);
    chk("bp O", 32'(o[0]), 32'h006);
    for (int i = 0; i < 10; i++) begin
      iv[0] = i[0]; a_in[0] = 8'(i); b_in[0] = 8'd200;
      @(posedge clk); #1;
      chk("bp hold out_valid", 32'(ov[0]), 32'd1);
      chk("bp hold O", 32'(o[0]), 32'h006);
      chk("bp hold in_ready", 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp release out_valid", 32'(ov[0]), 32'd0);
    chk("bp release in_ready", 32'(ir[0]), 32'd1);
    chk("bp release O stable", 32'(o[0]), 32'h006);
    @(posedge clk); #1;
    chk("bp no stray op", 32'(bsy[0]), 32'd0);

    // Reset in the middle of RUN
    a_in[0] = 8'd200; b_in[0] = 8'd100; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-run busy", 32'(bsy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset O", 32'(o[0]), 32'd0);
    chk("async reset out_valid", 32'(ov[0]), 32'd0);
    chk("async reset busy", 32'(bsy[0]), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 8'd0, 8'd1, 9'h1FF, 8, "u 0-1 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
